// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    RESP      = 2'd2,
    LOW_POWER = 2'd3
  } state_t;

  localparam int NUM_REQ_DEF      = 4;
  localparam int AW_DEF           = 4;
  localparam int DW_DEF           = 8;
  localparam int IDLE_TIMEOUT_DEF = 10;
  localparam int ACK_TIMEOUT_DEF  = 15;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after ptr, with wrap.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win_oh,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Scan ptr+1 .. ptr+N (mod N) and keep the first requester found.
  always_comb begin
    int            c;
    logic [IW-1:0] ci;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    c       = 0;
    ci      = '0;
    for (int i = 1; i <= N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!any && req[ci]) begin
        any         = 1'b1;
        win_idx     = ci;
        win_oh[ci]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin scheduler sharing one memory port among NUM_REQ requesters,
// with an ack watchdog and an idle power-down state.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_rw,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_ack,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  low_power
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
  localparam int ACW = $clog2(ACK_TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               req_any;
  logic [ICW-1:0]     idle_cnt, idle_inc;
  logic [ACW-1:0]     ack_cnt, ack_inc;
  logic               idle_expire, ack_expire, accept, finish;
  logic               sel_rw;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic [NUM_REQ-1:0] cmd_oh;
  logic               cmd_rw;
  logic [AW-1:0]      cmd_addr;
  logic [DW-1:0]      cmd_wdata;
  logic [DW-1:0]      rsp_data_q;
  logic               rsp_err_q;

  // Counters stop at their limit instead of wrapping.
  function automatic int sat_inc(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (req_any)
  );

  assign idle_inc    = ICW'(sat_inc(int'(idle_cnt), IDLE_TIMEOUT));
  assign ack_inc     = ACW'(sat_inc(int'(ack_cnt), ACK_TIMEOUT));
  assign idle_expire = (int'(idle_inc) == IDLE_TIMEOUT);
  assign ack_expire  = (int'(ack_inc) == ACK_TIMEOUT);
  assign accept      = (state == IDLE) && req_any;
  assign finish      = (state == BUSY) && (mem_ack || ack_expire);

  // Mux out the winner's command using constant slice positions.
  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state logic; an ack in the timeout cycle still counts as success.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_any)          state_nxt = BUSY;
        else if (idle_expire) state_nxt = LOW_POWER;
      end
      BUSY:      if (mem_ack || ack_expire) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      LOW_POWER: if (req_any) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state; data outputs are forced to 0 outside their phase.
  always_comb begin
    grant     = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_req   = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    low_power = 1'b0;
    case (state)
      BUSY: begin
        mem_req   = 1'b1;
        mem_rw    = cmd_rw;
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
        if (ack_cnt == '0) grant = cmd_oh;
      end
      RESP: begin
        rsp_valid = cmd_oh;
        rsp_rdata = rsp_data_q;
        rsp_err   = rsp_err_q;
      end
      LOW_POWER: low_power = 1'b1;
      default: ;
    endcase
  end

  // Control state: FSM, round-robin pointer and the two counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= IW'(NUM_REQ - 1);
      idle_cnt <= '0;
      ack_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ptr <= win_idx;
      if (state == IDLE) idle_cnt <= req_any ? '0 : idle_inc;
      else               idle_cnt <= '0;
      if (state == BUSY) ack_cnt <= ack_inc;
      else               ack_cnt <= '0;
    end
  end

  // Command latch taken when a requester wins arbitration.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_oh    <= win_oh;
      cmd_rw    <= sel_rw;
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
    end
  end

  // Response capture: read data on ack, zero for writes and aborts.
  always_ff @(posedge clk) begin
    if (finish) begin
      rsp_data_q <= (mem_ack && !cmd_rw) ? mem_rdata : '0;
      rsp_err_q  <= !mem_ack;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: cycle table plus corner sequences.
module tb_mem_port_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int AW           = 4;
  localparam int DW           = 8;
  localparam int IDLE_TIMEOUT = 10;
  localparam int ACK_TIMEOUT  = 15;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    req_rw = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;
  logic                  mem_req;
  logic                  mem_rw;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic                  mem_ack = 1'b0;
  logic [DW-1:0]         mem_rdata = '0;
  logic                  low_power;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW),
    .IDLE_TIMEOUT(IDLE_TIMEOUT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .low_power(low_power)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rw;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic [3:0]  e_grant;
    logic [3:0]  e_rsp_valid;
    logic [7:0]  e_rsp_rdata;
    logic        e_rsp_err;
    logic        e_mem_req;
    logic        e_mem_rw;
    logic [3:0]  e_mem_addr;
    logic [7:0]  e_mem_wdata;
    logic        e_low_power;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [31:0] out_bus();
    return {grant, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_rw,
            mem_addr, mem_wdata, low_power};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] rw, input logic [15:0] a,
                       input logic [31:0] wd, input logic ack, input logic [7:0] rd);
    req = r; req_rw = rw; req_addr = a; req_wdata = wd; mem_ack = ack; mem_rdata = rd;
  endtask

  initial begin
    logic [3:0] eg;
    // One row per clock cycle: inputs during the cycle, outputs expected in it.
    // Starts in LOW_POWER: write wake-up of requester 1, then a read by requester 2.
    tbl[0]  = '{4'b0010, 4'b0010, 16'h00F0, 32'h0000_3C00, 1'b0, 8'h00,
                4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1};
    tbl[1]  = '{4'b0010, 4'b0010, 16'h00F0, 32'h0000_3C00, 1'b0, 8'h00,
                4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    tbl[2]  = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b1, 8'h55,
                4'b0010, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 4'hF, 8'h3C, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b0, 8'h00,
                4'h0, 4'b0010, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0000, 16'h0500, 32'h0, 1'b0, 8'h00,
                4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b0, 8'h00,
                4'b0100, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h5, 8'h00, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b0, 8'h00,
                4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h5, 8'h00, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b1, 8'hA7,
                4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h5, 8'h00, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b1, 8'h11,
                4'h0, 4'b0100, 8'hA7, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b1, 8'hFF,
                4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 16'h0000, 32'h0, 1'b0, 8'h00,
                4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};

    // Reset state, then request-free IDLE cycles before power-down.
    repeat (2) @(negedge clk);
    check("reset_outputs", out_bus(), 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i < IDLE_TIMEOUT; i++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", i), out_bus(), 32'h0);
    end

    // Table: row 0 is the first LOW_POWER cycle.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].rdata);
      check($sformatf("row%0d", i), out_bus(),
            {tbl[i].e_grant, tbl[i].e_rsp_valid, tbl[i].e_rsp_rdata, tbl[i].e_rsp_err,
             tbl[i].e_mem_req, tbl[i].e_mem_rw, tbl[i].e_mem_addr, tbl[i].e_mem_wdata,
             tbl[i].e_low_power});
    end

    // Full contention from reset, ack in the first BUSY cycle: grants 0,1,2,3,0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    drive(4'b1111, 4'b0000, 16'h0, 32'h0, 1'b1, 8'h00);
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      eg = (c % 3 == 1) ? (4'b0001 << (((c - 1) / 3) % 4)) : 4'b0000;
      check($sformatf("contention_c%0d", c), {28'h0, grant}, {28'h0, eg});
    end
    drive(4'b0000, 4'b0000, 16'h0, 32'h0, 1'b0, 8'h00);

    // Watchdog abort: no ack for ACK_TIMEOUT BUSY cycles.
    @(negedge clk);
    drive(4'b0001, 4'b0000, 16'h0003, 32'h0, 1'b0, 8'h00);
    for (int c = 1; c <= ACK_TIMEOUT; c++) begin
      @(negedge clk);
      if (c == 1) drive(4'b0000, 4'b0000, 16'h0, 32'h0, 1'b0, 8'h00);
      check($sformatf("wd_busy_c%0d", c), {31'h0, mem_req}, 32'h1);
    end
    @(negedge clk);
    check("wd_abort_rsp", {20'h0, rsp_valid, rsp_rdata}, {20'h0, 4'b0001, 8'h00});
    check("wd_abort_err", {31'h0, rsp_err}, 32'h1);

    // Ack in the same cycle as the timeout: success wins.
    @(negedge clk);
    drive(4'b0001, 4'b0000, 16'h0003, 32'h0, 1'b0, 8'h00);
    for (int c = 1; c <= ACK_TIMEOUT; c++) begin
      @(negedge clk);
      if (c == 1) drive(4'b0000, 4'b0000, 16'h0, 32'h0, 1'b0, 8'h00);
      if (c == ACK_TIMEOUT) begin
        drive(4'b0000, 4'b0000, 16'h0, 32'h0, 1'b1, 8'h9E);
        check("wd_late_busy", {31'h0, mem_req}, 32'h1);
      end
    end
    @(negedge clk);
    drive(4'b0000, 4'b0000, 16'h0, 32'h0, 1'b0, 8'h00);
    check("wd_late_rsp", {19'h0, rsp_valid, rsp_rdata, rsp_err}, {19'h0, 4'b0001, 8'h9E, 1'b0});

    // Asynchronous reset while BUSY; pointer must restart at requester 0.
    @(negedge clk);
    drive(4'b0001, 4'b0000, 16'h0007, 32'h0, 1'b0, 8'h00);
    @(negedge clk);
    check("pre_reset_grant", {28'h0, grant}, {28'h0, 4'b0001});
    drive(4'b0000, 4'b0000, 16'h0, 32'h0, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("reset_async_drop", {27'h0, grant, mem_req}, 32'h0);
    @(negedge clk);
    check("reset_no_rsp", out_bus(), 32'h0);
    drive(4'b0011, 4'b0000, 16'h0000, 32'h0, 1'b0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_grant", {28'h0, grant}, {28'h0, 4'b0001});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin scheduler that shares the single memory port of the multi-port memory controller among NUM_REQ requesters. It latches one requester's command, drives it onto the memory port with a req/ack handshake, and returns a per-requester completion pulse with read data. It also guards against a hung memory with an ack watchdog, and enters a low-power state after a programmable idle period.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- AW, 4, address width
- DW, 8, data width
- IDLE_TIMEOUT, 10, consecutive request-free IDLE cycles before entering LOW_POWER
- ACK_TIMEOUT, 15, BUSY cycles without mem_ack before the transaction is aborted

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request level
- req_rw  in  NUM_REQ  per-requester direction: 1 = write, 0 = read
- req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
- grant  out  NUM_REQ  one-hot, one-cycle pulse: command accepted
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DW  read data, qualified by rsp_valid
- rsp_err  out  1  abort flag, qualified by rsp_valid
- mem_req  out  1  memory request, held until ack
- mem_rw  out  1  memory direction
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory completion
- mem_rdata  in  DW  memory read data, valid with mem_ack
- low_power  out  1  high while in LOW_POWER

## Operation
- States: IDLE, BUSY, RESP, LOW_POWER.
- Reset state is IDLE. All outputs are 0. The round-robin pointer is NUM_REQ-1, so requester 0 wins first. Both counters are 0.
- **IDLE.** If any req bit is high:
  - Select the winner w as the first requester with req set, searching from ptr+1 with modulo wrap.
  - Latch w, req_rw[w], req_addr[w] and req_wdata[w]. Set ptr = w.
  - Go to BUSY.
- **IDLE, no request.** idle_cnt increments. When idle_cnt reaches IDLE_TIMEOUT, go to LOW_POWER. Any request resets idle_cnt to 0.
- **BUSY.**
  - mem_req = 1. mem_rw, mem_addr and mem_wdata come from the latched command.
  - grant[w] = 1 in the first BUSY cycle only.
  - ack_cnt increments every BUSY cycle.
  - On mem_ack: capture mem_rdata for a read, or 0 for a write; clear rsp_err; go to RESP.
  - If ack_cnt reaches ACK_TIMEOUT with no ack: capture rdata = 0, set rsp_err = 1, go to RESP.
- **RESP.** rsp_valid[w] = 1 for one cycle with rsp_rdata and rsp_err. Then go to IDLE.
- **LOW_POWER.** low_power = 1 and mem_req = 0. Any req bit high → IDLE on the next cycle. idle_cnt clears on exit.
- Requester obligations:
  - Hold req and its command stable until grant is seen.
  - Drop req within one cycle of grant, or it re-enters arbitration.
  - A req that drops after latch does not cancel the transaction.
- Outside BUSY, mem_ack is ignored. mem_wdata and mem_addr are 0 outside BUSY.
- Counter widths are $clog2(TIMEOUT+1). Counters saturate and never wrap.

## Timing
- Request high at edge 0 (IDLE) → BUSY from cycle 1: mem_req = 1, grant pulse in cycle 1.
- mem_ack in cycle k (k ≥ 1; an ack in cycle 1 is legal) → rsp_valid in cycle k+1 → IDLE in cycle k+2.
- Minimum transaction is 3 cycles. Back-to-back service therefore issues a new grant every 3 cycles at the fastest.
- If mem_ack and the timeout occur in the same cycle, the ack wins: rsp_err = 0.
- Abort: BUSY entered in cycle 1, no ack → RESP in cycle ACK_TIMEOUT+1 with rsp_err = 1.
- Fairness: with all requesters continuously requesting, the grant order is 0,1,…,NUM_REQ-1,0,…
- LOW_POWER entry: IDLE_TIMEOUT request-free IDLE cycles → low_power rises on the next edge. A req in the LOW_POWER cycle → IDLE next cycle, grant two cycles later.
- Asynchronous reset mid-transaction:
  - Immediately returns to IDLE with all outputs 0.
  - The in-flight command is dropped with no rsp_valid.
  - ptr is reset.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY, RESP, LOW_POWER) and default parameter constants.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot winner, index, any flag.
- Top module: FSM, command/response latches, idle and ack counters.

## Test plan
- **Reset and idle power-down.** Reset, no requests, IDLE_TIMEOUT = 10 → low_power rises after 10 IDLE cycles; all other outputs stay 0.
- **Single read.** req[2] read at addr 4'h5, mem_ack in cycle 3 with rdata 8'hA7 → grant = 4'b0100 in cycle 1, rsp_valid = 4'b0100 with rsp_rdata = 8'hA7 in cycle 4.
- **Full contention.** All four requesters held high, ack after 1 cycle → grant order 0,1,2,3,0; each grant 3 cycles apart.
- **Ack watchdog.** No mem_ack for ACK_TIMEOUT = 15 → rsp_valid with rsp_err = 1 and rsp_rdata = 0; also check that an ack exactly at cycle 15 returns rsp_err = 0.
- **Write and wake.** From LOW_POWER, req[1] write of 8'h3C to addr 4'hF → low_power falls next cycle; mem_rw = 1, mem_addr = F, mem_wdata = 3C; rsp_rdata = 0.
- **Reset mid-operation.** rst_n asserted while BUSY → mem_req and grant drop immediately, no rsp_valid; the next request from requester 0 is granted first.
